// File: rtl/aca_pkg.sv
// Shared types and constants for the variable-latency almost-correct adder.
package aca_pkg;

  localparam int ACA_WIDTH_DEF  = 16;
  localparam int ACA_WINDOW_DEF = 6;
  localparam int ACA_CNT_W      = 16;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    HOLD  = 2'd1,
    FIX   = 2'd2
  } aca_state_e;

endpackage

// File: rtl/aca_spec_core.sv
// Combinational speculative adder: each carry only looks back WINDOW bits,
// plus a conservative detector for propagate runs that could break that guess.
module aca_spec_core #(
  parameter int WIDTH  = 16,
  parameter int WINDOW = 6
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] spec_sum,
  output logic             spec_carry,
  output logic             spec_err
);

  logic [WIDTH-1:0]      p;
  logic [WIDTH-1:0]      g;
  logic [WIDTH:0]        spec_c;
  logic [WIDTH-WINDOW:1] run_hit;

  assign p = a ^ b;
  assign g = a & b;

  genvar gi;

  // Carry into bit gi rippled over a bounded window; the true carry-in only
  // reaches bits close enough to the LSB to see it inside their window.
  for (gi = 0; gi <= WIDTH; gi++) begin : g_carry
    localparam int LO     = (gi > WINDOW) ? gi - WINDOW : 0;
    localparam bit SEEDED = (gi <= WINDOW);
    logic c_w;

    always_comb begin
      c_w = SEEDED ? carry_in : 1'b0;
      for (int j = LO; j < gi; j++) begin
        c_w = g[j] | (p[j] & c_w);
      end
    end

    assign spec_c[gi] = c_w;
  end

  for (gi = 0; gi < WIDTH; gi++) begin : g_sum
    assign spec_sum[gi] = p[gi] ^ spec_c[gi];
  end

  assign spec_carry = spec_c[WIDTH];

  // Any WINDOW-long propagate run starting above bit 0 may hide a carry.
  for (gi = 1; gi <= WIDTH - WINDOW; gi++) begin : g_detect
    assign run_hit[gi] = &p[gi+WINDOW-1:gi];
  end

  assign spec_err = |run_hit;

endmodule

// File: rtl/variable_latency_aca.sv
// Variable-latency adder: speculative result in one cycle, with an optional
// extra FIX cycle that replaces flagged results by the exact sum.
module variable_latency_aca
  import aca_pkg::*;
#(
  parameter int WIDTH      = ACA_WIDTH_DEF,
  parameter int WINDOW     = ACA_WINDOW_DEF,
  parameter int CORRECT_EN = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [WIDTH-1:0]     input1_i,
  input  logic [WIDTH-1:0]     input2_i,
  input  logic                 carry_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  output logic [WIDTH-1:0]     sum_o,
  output logic                 carry_o,
  output logic                 err_o,
  output logic                 approx_o,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [ACA_CNT_W-1:0] err_count_o
);

  localparam bit CORR = (CORRECT_EN != 0);

  aca_state_e state_reg, state_next, load_state;

  logic [WIDTH-1:0]     opa_reg, opb_reg;
  logic                 cin_reg;
  logic [WIDTH-1:0]     sum_reg;
  logic                 carry_reg, err_reg, approx_reg;
  logic [ACA_CNT_W-1:0] err_count_reg;

  logic [WIDTH-1:0] spec_sum;
  logic             spec_carry, spec_err;
  logic [WIDTH:0]   exact;
  logic             in_ready, out_valid, accept;

  aca_spec_core #(
    .WIDTH  (WIDTH),
    .WINDOW (WINDOW)
  ) u_spec_core (
    .a          (input1_i),
    .b          (input2_i),
    .carry_in   (carry_i),
    .spec_sum   (spec_sum),
    .spec_carry (spec_carry),
    .spec_err   (spec_err)
  );

  // Exact sum is only needed in FIX, so it works from the captured operands.
  assign exact = {1'b0, opa_reg} + {1'b0, opb_reg} + (WIDTH+1)'(cin_reg);

  assign load_state = (spec_err && CORR) ? FIX : HOLD;

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    accept     = 1'b0;

    case (state_reg)
      EMPTY: in_ready = 1'b1;
      HOLD: begin
        out_valid = 1'b1;
        in_ready  = out_ready_i;
      end
      default: ;
    endcase

    // Nothing handshakes while reset is asserted, including a pending HOLD.
    if (rst_i) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end

    accept = in_valid_i && in_ready;

    case (state_reg)
      EMPTY:   if (accept) state_next = load_state;
      HOLD:    if (out_ready_i) state_next = accept ? load_state : EMPTY;
      FIX:     state_next = HOLD;
      default: state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg     <= EMPTY;
      opa_reg       <= '0;
      opb_reg       <= '0;
      cin_reg       <= 1'b0;
      sum_reg       <= '0;
      carry_reg     <= 1'b0;
      err_reg       <= 1'b0;
      approx_reg    <= 1'b0;
      err_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        opa_reg    <= input1_i;
        opb_reg    <= input2_i;
        cin_reg    <= carry_i;
        sum_reg    <= spec_sum;
        carry_reg  <= spec_carry;
        err_reg    <= spec_err;
        approx_reg <= spec_err;
        if (spec_err && (err_count_reg != '1)) begin
          err_count_reg <= err_count_reg + ACA_CNT_W'(1);
        end
      end else if (state_reg == FIX) begin
        sum_reg    <= exact[WIDTH-1:0];
        carry_reg  <= exact[WIDTH];
        approx_reg <= 1'b0;
      end
    end
  end

  assign in_ready_o  = in_ready;
  assign out_valid_o = out_valid;
  assign sum_o       = sum_reg;
  assign carry_o     = carry_reg;
  assign err_o       = err_reg;
  assign approx_o    = approx_reg;
  assign err_count_o = err_count_reg;

endmodule

// File: doc/variable_latency_aca.md
VARIABLE_LATENCY_ACA -- requirements
Module: variable_latency_aca

Interface
REQ-001 Parameter WIDTH, default 16: operand and sum width, legal range 8..64.
REQ-002 Parameter WINDOW, default 6: speculative carry window length, legal range 2..WIDTH-1.
REQ-003 Parameter CORRECT_EN, default 1: 1 = flagged results are corrected, 0 = results are always speculative.
REQ-004 Port list, one clock; reset is synchronous and active-high.
- clk_i  input  1  clock; all state changes on the rising edge.
- rst_i  input  1  synchronous active-high reset.
- input1_i  input  WIDTH  operand A.
- input2_i  input  WIDTH  operand B.
- carry_i  input  1  carry-in.
- in_valid_i  input  1  operands valid.
- in_ready_o  output  1  block accepts operands.
- sum_o  output  WIDTH  result.
- carry_o  output  1  result carry-out.
- err_o  output  1  the window detector flagged this result.
- approx_o  output  1  sum_o/carry_o are speculative (flagged and not corrected).
- out_valid_o  output  1  result valid.
- out_ready_i  input  1  consumer accepts the result.
- err_count_o  output  16  saturating count of flagged results.

Function
REQ-005 Operands are accepted when in_valid_i && in_ready_o, and are registered at that edge.
REQ-006 The per-bit terms are p = A^B and g = A&B.
REQ-007 The speculative carry into bit i is the ripple of g/p over bits max(0,i-WINDOW)..i-1, seeded with carry_i if i<=WINDOW and with 0 otherwise. The speculative carry_o uses the same rule at i=WIDTH.
REQ-008 err is asserted iff there is a k in 1..WIDTH-WINDOW with p[k..k+WINDOW-1] all 1. This is a conservative detector.
REQ-009 The exact result is the full (WIDTH+1)-bit value A+B+carry_i.
REQ-010 FSM states:
- EMPTY: in_ready_o=1, out_valid_o=0.
- HOLD: out_valid_o=1, in_ready_o=out_ready_i.
- FIX: in_ready_o=0, out_valid_o=0.
REQ-011 On acceptance, if err && CORRECT_EN, go to FIX; otherwise go to HOLD holding the speculative result with approx_o=err.
REQ-012 FIX lasts exactly one cycle, then goes to HOLD with the exact result, err_o=1 and approx_o=0.
REQ-013 Latency from acceptance to out_valid_o is 1 cycle when unflagged (or when CORRECT_EN=0), and 2 cycles when flagged and corrected.
REQ-014 HOLD transitions:
- out_ready_i && in_valid_i: load the new operands (to HOLD or FIX); throughput is 1 result/cycle.
- out_ready_i && !in_valid_i: go to EMPTY.
- !out_ready_i: remain in HOLD with all outputs stable.
REQ-015 sum_o, carry_o, err_o and approx_o change only on an acceptance edge or on the FIX->HOLD edge.
REQ-016 err_count_o increments by 1 at each acceptance whose err=1, and saturates at 16'hFFFF.
REQ-017 Carry wrap: carry_o holds bit WIDTH of the (exact or speculative) sum; the sum wraps modulo 2^WIDTH.

Reset
REQ-018 Reset forces:
- state EMPTY, in_ready_o=0 during reset and 1 on the first cycle after;
- out_valid_o=0, sum_o=0, carry_o=0, err_o=0, approx_o=0, err_count_o=0.
REQ-019 Reset asserted in HOLD or FIX discards the pending result. No output handshake occurs for it.

Structure
REQ-020 Package aca_pkg SHALL hold:
- the state enum {EMPTY, HOLD, FIX};
- the default WIDTH and WINDOW constants;
- the counter width constant (16).
REQ-021 Sub-module aca_spec_core is combinational and SHALL produce the speculative sum, the speculative carry and err from A, B and carry_i. The top level holds the FSM, registers, exact adder and counter.

Verification
REQ-022 Bench uses WIDTH=16, WINDOW=6.
- Unflagged: 0x1234 + 0x0101, carry_i=0 -> sum_o=0x1335, carry_o=0, err_o=0, approx_o=0, out_valid_o 1 cycle after acceptance.
REQ-023 CORRECT_EN=1, 0x00FF + 0x0001 -> FIX for one cycle (in_ready_o=0), then sum_o=0x0100, err_o=1, approx_o=0, valid 2 cycles after acceptance, err_count_o=1.
REQ-024 CORRECT_EN=0, same operands -> sum_o=0x0080, err_o=1, approx_o=1, valid 1 cycle after acceptance.
REQ-025 Back-pressure and streaming:
- Hold out_ready_i=0 for 5 cycles in HOLD -> outputs stable, in_ready_o=0, no operand lost.
- Then stream 8 unflagged operand pairs with out_ready_i=1 -> one result per cycle, in order.
REQ-026 Carry-out: 0xFFFF + 0x0001, CORRECT_EN=1 -> sum_o=0x0000, carry_o=1, err_o=1.
REQ-027 Reset mid-FIX -> next cycle out_valid_o=0, err_count_o=0, state EMPTY.
REQ-028 Saturation: force 65537 flagged results -> err_count_o=0xFFFF.
